ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ahb_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: five-master AHB bus arbiter with rotating priority.
//   Master 0 is the default master; masters 1-4 request via hbusreq[4:1].
//   Fixed-length bursts (INCR4/8/16, WRAP4/8/16) are not interrupted: a beat
//   counter blocks re-arbitration until the last beat is in the address phase.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   hbusreq[4:0]         bus request per master (bit 0 ignored)
//   hlock[4:0]           locked-transfer request per master
//   hready               transfer-complete indication
//   htrans[1:0]          transfer type of the current address phase
//   hburst[2:0]          burst type of the current address phase
//   hgrant[4:0]          registered one-hot grant
//   hmaster[2:0]         index of the master owning the address phase
//   hmastlock            current address-phase transfer is locked
//
// Configuration:
//   ARB_LOCK_EN          when defined, a granted master holding hlock and
//                        hbusreq keeps the bus and hmastlock follows its hlock;
//                        when undefined, hlock is ignored and hmastlock is 0.

module ahb_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] hbusreq,
  input  logic [4:0] hlock,
  input  logic       hready,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  output logic [4:0] hgrant,
  output logic [2:0] hmaster,
  output logic       hmastlock
);

  localparam int unsigned NUM_M  = 5;
  localparam int unsigned NUM_RQ = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [NUM_M-1:0] hgrant_q, hgrant_d;
  logic [IDX_W-1:0] hmaster_q, hmaster_d;
  logic             hmastlock_q, hmastlock_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic [IDX_W-1:0] grant_idx_c;
  logic             lock_hold_c;
  logic             fixed_burst_c;
  logic [CNT_W-1:0] burst_len_c;
  logic             arb_point_c;
  logic [IDX_W-1:0] win_idx_c;
  logic             win_found_c;
  int unsigned      cand_c;
  logic             unused_c;

  // Index of the currently granted master (grant is always one-hot).
  always_comb begin
    grant_idx_c = '0;
    case (hgrant_q)
      5'b00010: grant_idx_c = IDX_W'(1);
      5'b00100: grant_idx_c = IDX_W'(2);
      5'b01000: grant_idx_c = IDX_W'(3);
      5'b10000: grant_idx_c = IDX_W'(4);
      default:  grant_idx_c = '0;
    endcase
  end

`ifdef ARB_LOCK_EN
  // Master 0 never requests, so it can never hold a lock.
  assign lock_hold_c = (grant_idx_c != '0) & hlock[grant_idx_c] & hbusreq[grant_idx_c];
  assign unused_c    = hburst[0];
`else
  assign lock_hold_c = 1'b0;
  assign unused_c    = ^{hlock, hbusreq[0], hburst[0]};
`endif

  // Burst length decode: only hburst[2:1] matters, WRAP and INCR share lengths.
  always_comb begin
    fixed_burst_c = (hburst[2:1] != 2'b00);
    burst_len_c   = '0;
    case (hburst[2:1])
      2'b01:   burst_len_c = CNT_W'(3);
      2'b10:   burst_len_c = CNT_W'(7);
      2'b11:   burst_len_c = CNT_W'(15);
      default: burst_len_c = '0;
    endcase
  end

  assign arb_point_c = hready & ~lock_hold_c
                     & ~((htrans == TR_NONSEQ) & fixed_burst_c)
                     & ~(beat_cnt_q > CNT_W'(1));

  // Rotating search: starting after last_q, wrapping through masters 1..4.
  always_comb begin
    win_idx_c   = '0;
    win_found_c = 1'b0;
    cand_c      = 0;
    for (int unsigned k = 0; k < NUM_RQ; k++) begin
      cand_c = ((32'(last_q) + k) % NUM_RQ) + 1;
      if (!win_found_c && hbusreq[IDX_W'(cand_c)]) begin
        win_idx_c   = IDX_W'(cand_c);
        win_found_c = 1'b1;
      end
    end
  end

  // Next-state for grant, pointer, beat counter and address-phase owner.
  always_comb begin
    hgrant_d    = hgrant_q;
    last_d      = last_q;
    beat_cnt_d  = beat_cnt_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;

    if (arb_point_c) begin
      hgrant_d = '0;
      if (win_found_c) begin
        hgrant_d[win_idx_c] = 1'b1;
        last_d              = win_idx_c;
      end else begin
        hgrant_d[0] = 1'b1;
        last_d      = '0;
      end
    end

    if (hready) begin
      case (htrans)
        TR_NONSEQ: beat_cnt_d = fixed_burst_c ? burst_len_c : '0;
        TR_SEQ:    if (beat_cnt_q != '0) beat_cnt_d = beat_cnt_q - CNT_W'(1);
        TR_BUSY:   beat_cnt_d = beat_cnt_q;
        TR_IDLE:   beat_cnt_d = '0;
        default:   beat_cnt_d = beat_cnt_q;
      endcase
      hmaster_d = grant_idx_c;
`ifdef ARB_LOCK_EN
      hmastlock_d = hlock[grant_idx_c];
`else
      hmastlock_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hgrant_q    <= NUM_M'(1);
      hmaster_q   <= '0;
      hmastlock_q <= 1'b0;
      beat_cnt_q  <= '0;
      last_q      <= '0;
    end else begin
      hgrant_q    <= hgrant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
      beat_cnt_q  <= beat_cnt_d;
      last_q      <= last_d;
    end
  end

  assign hgrant    = hgrant_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: scenario bench for ahb_arbiter. Each stimulus row carries
// the hand-derived grant expected after the edge; hmaster/hmastlock expectations
// follow from the previous expected grant. Expectations are queued when a row is
// driven and popped for comparison once the edge has happened.
// Covers both builds: the lock scenario expectations depend on ARB_LOCK_EN.

module tb_ahb_arbiter;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] NSEQ = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;

  typedef struct {
    logic [4:0] req;
    logic [4:0] lock;
    logic       rdy;
    logic [1:0] tr;
    logic [2:0] bu;
    logic [4:0] g;
  } row_t;

  typedef struct {
    logic [4:0] g;
    logic [2:0] m;
    logic       ml;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] hbusreq;
  logic [4:0] hlock;
  logic       hready;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic [4:0] hgrant;
  logic [2:0] hmaster;
  logic       hmastlock;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  logic [4:0] prev_g;
  logic [2:0] mdl_m;
  logic       mdl_ml;

  ahb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .hready    (hready),
    .htrans    (htrans),
    .hburst    (hburst),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] idx(input logic [4:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 5; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  function automatic row_t mk(input logic [4:0] req, input logic [4:0] lock, input logic rdy,
                              input logic [1:0] tr, input logic [2:0] bu, input logic [4:0] g);
    row_t r;
    r.req = req; r.lock = lock; r.rdy = rdy; r.tr = tr; r.bu = bu; r.g = g;
    return r;
  endfunction

  task automatic model_reset();
    prev_g = 5'b00001;
    mdl_m  = 3'd0;
    mdl_ml = 1'b0;
  endtask

  // Drive one row, queue its expectation, and advance to just after the edge.
  task automatic drive_row(input row_t r);
    logic [2:0] pi;
    exp_t e;
    hbusreq = r.req; hlock = r.lock; hready = r.rdy; htrans = r.tr; hburst = r.bu;
    pi = idx(prev_g);
    if (r.rdy) begin
      mdl_m = pi;
`ifdef ARB_LOCK_EN
      mdl_ml = r.lock[pi];
`else
      mdl_ml = 1'b0;
`endif
    end
    e.g = r.g; e.m = mdl_m; e.ml = mdl_ml;
    exp_q.push_back(e);
    prev_g = r.g;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hbusreq = 5'b0; hlock = 5'b0; hready = 1'b1; htrans = IDLE; hburst = SINGLE;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({hgrant, hmaster, hmastlock} !== {5'b00001, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: got grant=%b master=%0d mastlock=%b, want 00001/0/0", hgrant, hmaster, hmastlock);
    end
    hbusreq = 5'b11110;
    @(posedge clk);
    #1;
    n_cmp++;
    if (hgrant !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_hold: got grant=%b, want 00001", hgrant);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rotation();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(5'b11110, 5'b0, 1'b1, NSEQ, SINGLE, 5'b00010));
    rows.push_back(mk(5'b11110, 5'b0, 1'b1, NSEQ, SINGLE, 5'b00100));
    rows.push_back(mk(5'b11110, 5'b0, 1'b1, SEQ,  INCR,   5'b01000));
    rows.push_back(mk(5'b11110, 5'b0, 1'b1, SEQ,  INCR,   5'b10000));
    rows.push_back(mk(5'b11110, 5'b0, 1'b1, NSEQ, INCR,   5'b00010));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.ml}) begin
        n_bad++;
        $display("FAIL rotation[%0d]: got %b/%0d/%b, want %b/%0d/%b", i, hgrant, hmaster, hmastlock, e.g, e.m, e.ml);
      end
    end
  endtask

  task automatic test_incr4();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(5'b00100, 5'b0, 1'b1, IDLE, SINGLE, 5'b00100));
    rows.push_back(mk(5'b01100, 5'b0, 1'b1, NSEQ, INCR4,  5'b00100));
    rows.push_back(mk(5'b01100, 5'b0, 1'b1, SEQ,  INCR4,  5'b00100));
    rows.push_back(mk(5'b01100, 5'b0, 1'b1, SEQ,  INCR4,  5'b00100));
    rows.push_back(mk(5'b01100, 5'b0, 1'b1, SEQ,  INCR4,  5'b01000));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.ml}) begin
        n_bad++;
        $display("FAIL incr4[%0d]: got %b/%0d/%b, want %b/%0d/%b", i, hgrant, hmaster, hmastlock, e.g, e.m, e.ml);
      end
    end
  endtask

  task automatic test_hready_stall();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(5'b11000, 5'b0, 1'b1, NSEQ, INCR4, 5'b01000));
    rows.push_back(mk(5'b11000, 5'b0, 1'b1, SEQ,  INCR4, 5'b01000));
    rows.push_back(mk(5'b11000, 5'b0, 1'b0, SEQ,  INCR4, 5'b01000));
    rows.push_back(mk(5'b11000, 5'b0, 1'b0, SEQ,  INCR4, 5'b01000));
    rows.push_back(mk(5'b11000, 5'b0, 1'b0, SEQ,  INCR4, 5'b01000));
    rows.push_back(mk(5'b11000, 5'b0, 1'b1, BUSY, INCR4, 5'b01000));
    rows.push_back(mk(5'b11000, 5'b0, 1'b1, SEQ,  INCR4, 5'b01000));
    rows.push_back(mk(5'b11000, 5'b0, 1'b1, SEQ,  INCR4, 5'b10000));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.ml}) begin
        n_bad++;
        $display("FAIL stall[%0d]: got %b/%0d/%b, want %b/%0d/%b", i, hgrant, hmaster, hmastlock, e.g, e.m, e.ml);
      end
    end
  endtask

  task automatic test_idle_release();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(5'b01000, 5'b0, 1'b1, IDLE, SINGLE, 5'b01000));
    rows.push_back(mk(5'b00000, 5'b0, 1'b1, IDLE, SINGLE, 5'b00001));
    rows.push_back(mk(5'b00000, 5'b0, 1'b1, IDLE, SINGLE, 5'b00001));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.ml}) begin
        n_bad++;
        $display("FAIL idle_release[%0d]: got %b/%0d/%b, want %b/%0d/%b", i, hgrant, hmaster, hmastlock, e.g, e.m, e.ml);
      end
    end
  endtask

  task automatic test_early_term();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(5'b00010, 5'b0, 1'b1, IDLE, SINGLE, 5'b00010));
    rows.push_back(mk(5'b10010, 5'b0, 1'b1, NSEQ, INCR8,  5'b00010));
    rows.push_back(mk(5'b10010, 5'b0, 1'b1, SEQ,  INCR8,  5'b00010));
    rows.push_back(mk(5'b10010, 5'b0, 1'b1, IDLE, INCR8,  5'b00010));
    rows.push_back(mk(5'b10010, 5'b0, 1'b1, IDLE, INCR8,  5'b10000));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.ml}) begin
        n_bad++;
        $display("FAIL early_term[%0d]: got %b/%0d/%b, want %b/%0d/%b", i, hgrant, hmaster, hmastlock, e.g, e.m, e.ml);
      end
    end
  endtask

  task automatic test_lock();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(5'b00010, 5'b00010, 1'b1, IDLE, SINGLE, 5'b00010));
`ifdef ARB_LOCK_EN
    rows.push_back(mk(5'b10010, 5'b00010, 1'b1, NSEQ, INCR, 5'b00010));
    rows.push_back(mk(5'b10010, 5'b00010, 1'b1, NSEQ, INCR, 5'b00010));
`else
    rows.push_back(mk(5'b10010, 5'b00010, 1'b1, NSEQ, INCR, 5'b10000));
    rows.push_back(mk(5'b10010, 5'b00010, 1'b1, NSEQ, INCR, 5'b00010));
`endif
    rows.push_back(mk(5'b10010, 5'b00000, 1'b1, NSEQ, INCR, 5'b10000));
    rows.push_back(mk(5'b10000, 5'b00000, 1'b1, NSEQ, INCR, 5'b10000));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.ml}) begin
        n_bad++;
        $display("FAIL lock[%0d]: got %b/%0d/%b, want %b/%0d/%b", i, hgrant, hmaster, hmastlock, e.g, e.m, e.ml);
      end
    end
  endtask

  task automatic test_reset_midburst();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(5'b01000, 5'b0, 1'b1, IDLE, SINGLE, 5'b01000));
    rows.push_back(mk(5'b01000, 5'b0, 1'b1, NSEQ, INCR8,  5'b01000));
    rows.push_back(mk(5'b01000, 5'b0, 1'b1, SEQ,  INCR8,  5'b01000));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.ml}) begin
        n_bad++;
        $display("FAIL midburst[%0d]: got %b/%0d/%b, want %b/%0d/%b", i, hgrant, hmaster, hmastlock, e.g, e.m, e.ml);
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({hgrant, hmaster, hmastlock} !== {5'b00001, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL midburst_reset: got %b/%0d/%b, want 00001/0/0", hgrant, hmaster, hmastlock);
    end
    model_reset();
    hbusreq = 5'b11110; htrans = IDLE; hburst = SINGLE;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_row(mk(5'b11110, 5'b0, 1'b1, IDLE, SINGLE, 5'b00010));
    drive_row(mk(5'b11110, 5'b0, 1'b1, IDLE, SINGLE, 5'b00100));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (hgrant !== e.g && exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL after_reset: got grant=%b, want %b", hgrant, e.g);
      end
    end
  endtask

  // Checks the first post-reset arbitration separately, one row at a time.
  task automatic test_reset_order();
    exp_t e;
    rst_n = 1'b0;
    model_reset();
    hbusreq = 5'b10000; htrans = IDLE; hburst = SINGLE; hlock = 5'b0; hready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_row(mk(5'b11110, 5'b0, 1'b1, IDLE, SINGLE, 5'b00010));
    e = exp_q.pop_front();
    n_cmp++;
    if ({hgrant, hmaster, hmastlock} !== {e.g, e.m, e.ml}) begin
      n_bad++;
      $display("FAIL reset_order: got %b/%0d/%b, want %b/%0d/%b", hgrant, hmaster, hmastlock, e.g, e.m, e.ml);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rotation();
    test_incr4();
    test_hready_stall();
    test_idle_release();
    test_early_term();
    test_lock();
    test_reset_midburst();
    test_reset_order();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
